// File: rtl/gf2_poly_div.sv
// gf2_poly_div: bit-serial GF(2) polynomial long divider.
// Divides a (2N-1)-bit carry-less product by a monic degree-(N-1) divisor.
// Produces an N-bit quotient and an (N-1)-bit remainder over N RUN cycles.
// Handshakes on both sides (valid/ready); one job in flight at a time.
// Optional feature macro: GF2_DIV_MONIC_CHECK_EN. When it is defined, a
// divisor whose leading bit is 0 is rejected and reported through err.
module gf2_poly_div #(
  parameter int N = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-2:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     quotient,
  output logic [N-2:0]     remainder,
  output logic             err
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-2:0]     r_q;
  logic [N-2:0]     r_d;
  logic [N-1:0]     sh_q;
  logic [N-2:0]     dvs_q;
  logic [N-1:0]     quot_q;
  logic [N-1:0]     quot_d;
  logic [N-2:0]     rem_q;
  logic [N-1:0]     t;
  logic             qbit;
  logic             accept;
  logic             reject;
  logic             last;

`ifdef GF2_DIV_MONIC_CHECK_EN
  logic             err_q;
`else
  // The leading divisor bit is implied to be 1 in this build.
  logic             unused_divisor_msb;
  assign unused_divisor_msb = divisor[N-1];
`endif

  // One long-division step: bring down the next dividend bit, subtract (XOR)
  // the divisor when the leading coefficient is set.
  always_comb begin
    t      = {r_q, sh_q[N-1]};
    qbit   = t[N-1];
    r_d    = t[N-2:0] ^ (qbit ? dvs_q : '0);
    quot_d = {quot_q[N-2:0], qbit};
    accept = in_valid && in_ready_q;
    last   = (cnt_q == CNT_W'(N - 1));
`ifdef GF2_DIV_MONIC_CHECK_EN
    reject = ~divisor[N-1];
`else
    reject = 1'b0;
`endif
  end

  // Control FSM plus the shift/remainder datapath it sequences.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      r_q         <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
`ifdef GF2_DIV_MONIC_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (reject) begin
              // Non-monic divisor: skip the division and report the error.
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              quot_q      <= '0;
              rem_q       <= '0;
`ifdef GF2_DIV_MONIC_CHECK_EN
              err_q       <= 1'b1;
`endif
            end else begin
              state_q <= S_RUN;
              r_q     <= dividend[2*N-2:N];
              sh_q    <= dividend[N-1:0];
              dvs_q   <= divisor[N-2:0];
              cnt_q   <= '0;
            end
          end
        end
        S_RUN: begin
          r_q    <= r_d;
          sh_q   <= {sh_q[N-2:0], 1'b0};
          quot_q <= quot_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            rem_q       <= r_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
`ifdef GF2_DIV_MONIC_CHECK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef GF2_DIV_MONIC_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_gf2_poly_div.sv
// Testbench for gf2_poly_div (N=9): vector table, hand-written handshake,
// back-pressure and reset sequences, and randomized jobs, all checked through
// a scoreboard queue against an independent long-division model.
module tb_gf2_poly_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] dividend;
  logic [8:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  quotient;
  logic [7:0]  remainder;
  logic        err;

  gf2_poly_div #(.N(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] dvd;
    logic [8:0]  dvs;
    logic [8:0]  q;
    logic [7:0]  r;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t tbl[5];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    chk_cnt++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference long division; the divisor's leading bit is taken as 1.
  function automatic void ref_div(input logic [16:0] dvd, input logic [8:0] dvs,
                                  output logic [8:0] q, output logic [7:0] r);
    logic [16:0] rem;
    logic [16:0] d;
    d   = {8'b0, 1'b1, dvs[7:0]};
    rem = dvd;
    q   = '0;
    for (int i = 16; i >= 8; i--) begin
      if (rem[i]) begin
        q[i-8] = 1'b1;
        rem    = rem ^ (d << (i - 8));
      end
    end
    r = rem[7:0];
  endfunction

  function automatic logic [16:0] clmul(input logic [8:0] a, input logic [8:0] b);
    logic [16:0] p;
    p = '0;
    for (int i = 0; i < 9; i++)
      if (b[i]) p = p ^ (17'(a) << i);
    return p;
  endfunction

  // Result monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        fail("unexpected_result");
      end else begin
        mon_e = sbq.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("remainder", 32'(remainder), 32'(mon_e.r));
        chk("err", 32'(err), 32'(mon_e.e));
        if (!mon_e.e)
          chk("q*d^r", 32'(clmul(quotient, {1'b1, mon_e.dvs[7:0]}) ^ 17'(remainder)),
              32'(mon_e.dvd));
      end
    end
  end

  task automatic run_job(input logic [16:0] dvd, input logic [8:0] dvs,
                         input logic [8:0] q, input logic [7:0] r, input logic e,
                         input int lat_exp, input bit gaps);
    int n;
    int lat;
    int w;
    exp_t x;
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready) begin
      tick();
      n++;
      if (n > 100) begin
        fail("accept_timeout");
        in_valid = 1'b0;
        return;
      end
    end
    x.dvd = dvd; x.dvs = dvs; x.q = q; x.r = r; x.e = e;
    sbq.push_back(x);
    tick();
    in_valid = 1'b0;
    dividend = 17'($urandom);
    divisor  = 9'($urandom);
    chk("in_ready_busy", 32'(in_ready), 32'(0));
    lat = 0;
    while (!out_valid && lat < 100) begin
      out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    w = 0;
    while (out_valid && w < 200) begin
      out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      w++;
    end
    if (out_valid) fail("drain_timeout");
    out_ready = 1'b1;
  endtask

  initial begin
    logic [8:0]  rq;
    logic [7:0]  rr;
    logic [16:0] rd;
    logic [8:0]  rv;
    int          n;
    exp_t        x;

    tbl[0] = '{17'h02B79, 9'h11B, 9'h028, 8'hC1, 1'b0};
    tbl[1] = '{17'h0011B, 9'h11B, 9'h001, 8'h00, 1'b0};
    tbl[2] = '{17'h000FF, 9'h11B, 9'h000, 8'hFF, 1'b0};
    tbl[3] = '{17'h10000, 9'h100, 9'h100, 8'h00, 1'b0};
    tbl[4] = '{17'h00000, 9'h1A5, 9'h000, 8'h00, 1'b0};

    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst_n = 1'b1;
    tick();

    // Vector table.
    for (int i = 0; i < 5; i++)
      run_job(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].e, 9, 1'b0);

    // Back-pressure with a second job offered during the hold.
    out_ready = 1'b0;
    dividend = 17'h02B79; divisor = 9'h11B; in_valid = 1'b1;
    x = '{17'h02B79, 9'h11B, 9'h028, 8'hC1, 1'b0};
    sbq.push_back(x);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("bp_latency", 32'(n), 32'(9));
    dividend = 17'h0011B; divisor = 9'h11B; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_quotient", 32'(quotient), 32'h028);
      chk("bp_remainder", 32'(remainder), 32'hC1);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("hs_out_valid", 32'(out_valid), 32'(0));
    chk("hs_in_ready", 32'(in_ready), 32'(1));
    x = '{17'h0011B, 9'h11B, 9'h001, 8'h00, 1'b0};
    sbq.push_back(x);
    tick();
    chk("b_accepted", 32'(in_ready), 32'(0));
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("b_latency", 32'(n), 32'(9));
    n = 0;
    while (out_valid && n < 100) begin tick(); n++; end
    if (out_valid) fail("b_drain_timeout");

    // Reset in the 4th RUN cycle aborts the job with no output.
    dividend = 17'h02B79; divisor = 9'h11B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_quotient", 32'(quotient), 32'(0));
    chk("mid_rst_remainder", 32'(remainder), 32'(0));
    rst_n = 1'b1;
    tick();
    run_job(17'h02B79, 9'h11B, 9'h028, 8'hC1, 1'b0, 9, 1'b0);

    // Non-monic divisor.
`ifdef GF2_DIV_MONIC_CHECK_EN
    run_job(17'h02B79, 9'h0FF, 9'h000, 8'h00, 1'b1, 0, 1'b0);
`else
    ref_div(17'h02B79, 9'h0FF, rq, rr);
    run_job(17'h02B79, 9'h0FF, rq, rr, 1'b0, 9, 1'b0);
`endif

    // Randomized jobs with random out_ready gaps.
    for (int j = 0; j < 1000; j++) begin
      rd = 17'($urandom);
      rv = {1'b1, 8'($urandom)};
      ref_div(rd, rv, rq, rr);
      run_job(rd, rv, rq, rr, 1'b0, 9, 1'b1);
    end

    tick(); tick();
    if (sbq.size() != 0) fail("leftover_results");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
